// File: rtl/div_clk_monitor.sv
// Divided-clock checker: measures period/high time of a slow clock
// in the reference domain, flags duty errors, lock and stall.
module div_clk_monitor #(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_clk,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             duty_ok,
    output logic             locked,
    output logic             stall
);

    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t           state;
    logic             sync1;
    logic             s;
    logic             s_d;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] lo_cnt;
    logic [CNT_W-1:0] tmo_cnt;
    logic [LW-1:0]    lock_cnt;
    logic             have_ref;

    logic             rise;
    logic             fall;
    logic             publish;
    logic             tmo_hit;
    logic [CNT_W-1:0] hi_inc;
    logic [CNT_W-1:0] lo_inc;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] per_new;
    logic [CNT_W-1:0] diff;
    logic             duty_new;
    logic [LW-1:0]    lock_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            s_d   <= 1'b0;
        end else begin
            sync1 <= in_clk;
            s     <= sync1;
            s_d   <= s;
        end
    end

    always_comb begin
        rise     = s & ~s_d;
        fall     = ~s & s_d;
        publish  = (state == LOW) && rise;
        tmo_hit  = (tmo_cnt == TMO_LAST);
        hi_inc   = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + CNT_W'(1);
        lo_inc   = (lo_cnt == CNT_MAX) ? lo_cnt : lo_cnt + CNT_W'(1);
        sum      = {1'b0, hi_cnt} + {1'b0, lo_cnt};
        per_new  = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
        diff     = (hi_cnt >= lo_cnt) ? hi_cnt - lo_cnt : lo_cnt - hi_cnt;
        duty_new = (diff <= CNT_W'(1));
        lock_inc = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hi_cnt     <= '0;
            lo_cnt     <= '0;
            tmo_cnt    <= '0;
            lock_cnt   <= '0;
            have_ref   <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            duty_ok    <= 1'b0;
            locked     <= 1'b0;
            stall      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;

            // A publish completes even when en drops on the same cycle.
            if (publish) begin
                period     <= per_new;
                high_time  <= hi_cnt;
                duty_ok    <= duty_new;
                meas_valid <= 1'b1;
                if (!have_ref) begin
                    have_ref <= 1'b1;
                    lock_cnt <= '0;
                end else if (per_new == period) begin
                    lock_cnt <= lock_inc;
                    locked   <= (lock_inc == LOCK_MAX);
                end else begin
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                end
            end

            if (!en) begin
                state    <= IDLE;
                hi_cnt   <= '0;
                lo_cnt   <= '0;
                tmo_cnt  <= '0;
                lock_cnt <= '0;
                have_ref <= 1'b0;
                locked   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (rise) begin
                            state   <= HIGH;
                            hi_cnt  <= CNT_W'(1);
                            lo_cnt  <= '0;
                            tmo_cnt <= '0;
                            stall   <= 1'b0;
                        end
                    end
                    HIGH: begin
                        if (tmo_hit) begin
                            state    <= IDLE;
                            hi_cnt   <= '0;
                            lo_cnt   <= '0;
                            tmo_cnt  <= '0;
                            lock_cnt <= '0;
                            have_ref <= 1'b0;
                            locked   <= 1'b0;
                            stall    <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + CNT_W'(1);
                            if (fall) begin
                                state  <= LOW;
                                lo_cnt <= CNT_W'(1);
                            end else begin
                                hi_cnt <= hi_inc;
                            end
                        end
                    end
                    LOW: begin
                        // A rise on the timeout cycle wins over the stall.
                        if (rise) begin
                            state   <= HIGH;
                            hi_cnt  <= CNT_W'(1);
                            lo_cnt  <= '0;
                            tmo_cnt <= '0;
                        end else if (tmo_hit) begin
                            state    <= IDLE;
                            hi_cnt   <= '0;
                            lo_cnt   <= '0;
                            tmo_cnt  <= '0;
                            lock_cnt <= '0;
                            have_ref <= 1'b0;
                            locked   <= 1'b0;
                            stall    <= 1'b1;
                        end else begin
                            lo_cnt  <= lo_inc;
                            tmo_cnt <= tmo_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
